// File: rtl/booth_mul_arbiter.sv
// booth_mul_arbiter
// Round-robin scheduler that shares one sequential radix-4 Booth multiplier
// between N_REQ requesters. A granted request's operands are latched and held
// on the multiplier interface for the whole operation. The product is captured
// in the single cycle where mul_done is high. It is then returned on a shared
// response channel, tagged with the requester index. A watchdog turns a
// multiplier that never finishes into an error response (rsp_err=1, product 0).
//
// Ports
//   clk, rstn          clock, asynchronous active-low reset
//   req_vld/req_rdy    per-requester valid/ready (req_rdy combinational, one-hot or zero)
//   req_a/req_b        packed operands, requester i at [i*WIDTH +: WIDTH]
//   rsp_vld/rsp_rdy    shared response handshake
//   rsp_id/rsp_prod    requester index and signed product of the response
//   rsp_err            watchdog fired for this response
//   mul_vld/mul_a/mul_b  registered drive to the multiplier (vld must stay high)
//   mul_prod/mul_done  multiplier result, valid only in the mul_done cycle
//   busy               high whenever the scheduler is not idle
module booth_mul_arbiter #(
    parameter int N_REQ   = 4,
    parameter int WIDTH   = 8,
    parameter int ID_W    = 2,
    parameter int TIMEOUT = 32
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic [N_REQ-1:0]            req_vld,
    output logic [N_REQ-1:0]            req_rdy,
    input  logic [N_REQ*WIDTH-1:0]      req_a,
    input  logic [N_REQ*WIDTH-1:0]      req_b,
    output logic                        rsp_vld,
    input  logic                        rsp_rdy,
    output logic [ID_W-1:0]             rsp_id,
    output logic signed [2*WIDTH-1:0]   rsp_prod,
    output logic                        rsp_err,
    output logic                        mul_vld,
    output logic signed [WIDTH-1:0]     mul_a,
    output logic signed [WIDTH-1:0]     mul_b,
    input  logic signed [2*WIDTH-1:0]   mul_prod,
    input  logic                        mul_done,
    output logic                        busy
);

    localparam int WD_W = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, RUN, RESP} state_t;

    state_t                     state_q, state_d;
    logic [ID_W-1:0]            ptr_q, ptr_d;
    logic [ID_W-1:0]            gid_q, gid_d;
    logic [WD_W-1:0]            wd_q, wd_d;
    logic                       mul_vld_q, mul_vld_d;
    logic signed [WIDTH-1:0]    mul_a_q, mul_a_d;
    logic signed [WIDTH-1:0]    mul_b_q, mul_b_d;
    logic                       rsp_vld_q, rsp_vld_d;
    logic [ID_W-1:0]            rsp_id_q, rsp_id_d;
    logic signed [2*WIDTH-1:0]  rsp_prod_q, rsp_prod_d;
    logic                       rsp_err_q, rsp_err_d;

    logic signed [WIDTH-1:0]    a_arr [N_REQ];
    logic signed [WIDTH-1:0]    b_arr [N_REQ];
    logic [ID_W-1:0]            gnt_idx;
    logic [ID_W-1:0]            ptr_nxt;
    logic                       gnt_any;

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
        assign a_arr[gi] = req_a[gi*WIDTH +: WIDTH];
        assign b_arr[gi] = req_b[gi*WIDTH +: WIDTH];
    end

    // Round-robin pick: first pass takes the lowest active index at or above
    // the pointer; the second pass wraps around to the indices below it.
    always_comb begin
        gnt_idx = '0;
        gnt_any = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!gnt_any && req_vld[i] && (ID_W'(i) >= ptr_q)) begin
                gnt_any = 1'b1;
                gnt_idx = ID_W'(i);
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (!gnt_any && req_vld[i]) begin
                gnt_any = 1'b1;
                gnt_idx = ID_W'(i);
            end
        end
    end

    assign ptr_nxt = (gnt_idx == ID_W'(N_REQ-1)) ? '0 : gnt_idx + ID_W'(1);

    // Ready is gated with rstn so that no requester sees a transfer while the block is held in reset.
    assign req_rdy = (rstn && (state_q == IDLE) && gnt_any)
                   ? ({{(N_REQ-1){1'b0}}, 1'b1} << gnt_idx) : '0;

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        gid_d      = gid_q;
        wd_d       = wd_q;
        mul_vld_d  = mul_vld_q;
        mul_a_d    = mul_a_q;
        mul_b_d    = mul_b_q;
        rsp_vld_d  = rsp_vld_q;
        rsp_id_d   = rsp_id_q;
        rsp_prod_d = rsp_prod_q;
        rsp_err_d  = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (gnt_any) begin
                    mul_a_d   = a_arr[gnt_idx];
                    mul_b_d   = b_arr[gnt_idx];
                    gid_d     = gnt_idx;
                    mul_vld_d = 1'b1;
                    wd_d      = '0;
                    ptr_d     = ptr_nxt;
                    state_d   = RUN;
                end
            end
            RUN: begin
                // mul_prod is only valid during the done cycle, so it is captured right then.
                // Done takes priority over a watchdog expiry in the same cycle.
                if (mul_done) begin
                    rsp_prod_d = mul_prod;
                    rsp_err_d  = 1'b0;
                    rsp_id_d   = gid_q;
                    rsp_vld_d  = 1'b1;
                    mul_vld_d  = 1'b0;
                    state_d    = RESP;
                end else if (wd_q == WD_W'(TIMEOUT-1)) begin
                    rsp_prod_d = '0;
                    rsp_err_d  = 1'b1;
                    rsp_id_d   = gid_q;
                    rsp_vld_d  = 1'b1;
                    mul_vld_d  = 1'b0;
                    state_d    = RESP;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            RESP: begin
                // At least one cycle here keeps mul_vld low between operations.
                if (rsp_rdy) begin
                    rsp_vld_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            gid_q      <= '0;
            wd_q       <= '0;
            mul_vld_q  <= 1'b0;
            mul_a_q    <= '0;
            mul_b_q    <= '0;
            rsp_vld_q  <= 1'b0;
            rsp_id_q   <= '0;
            rsp_prod_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            gid_q      <= gid_d;
            wd_q       <= wd_d;
            mul_vld_q  <= mul_vld_d;
            mul_a_q    <= mul_a_d;
            mul_b_q    <= mul_b_d;
            rsp_vld_q  <= rsp_vld_d;
            rsp_id_q   <= rsp_id_d;
            rsp_prod_q <= rsp_prod_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    assign mul_vld  = mul_vld_q;
    assign mul_a    = mul_a_q;
    assign mul_b    = mul_b_q;
    assign rsp_vld  = rsp_vld_q;
    assign rsp_id   = rsp_id_q;
    assign rsp_prod = rsp_prod_q;
    assign rsp_err  = rsp_err_q;
    assign busy     = (state_q != IDLE);

endmodule
